// File: rtl/puf_challenge_verifier_if.sv
// puf_challenge_verifier_if: run control, PUF pins and enrolled-response stream of the verifier
// slave modport (verifier side):
//   in : start, abort, seed, puf_resp, exp_valid, exp_resp
//   out: puf_chal, puf_en, puf_clr, exp_ready, busy, done, pass,
//        last_resp, last_hd, mismatch_cnt, hd_total
// master modport (controller/environment side): same signals, opposite directions.
interface puf_challenge_verifier_if #(
  parameter int CHAL_W = 5,
  parameter int RESP_W = 8
);
  logic              start;
  logic              abort;
  logic [CHAL_W-1:0] seed;
  logic [CHAL_W-1:0] puf_chal;
  logic              puf_en;
  logic              puf_clr;
  logic [RESP_W-1:0] puf_resp;
  logic              exp_valid;
  logic [RESP_W-1:0] exp_resp;
  logic              exp_ready;
  logic              busy;
  logic              done;
  logic              pass;
  logic [RESP_W-1:0] last_resp;
  logic [3:0]        last_hd;
  logic [CHAL_W:0]   mismatch_cnt;
  logic [11:0]       hd_total;
  modport slave (
    input  start, abort, seed, puf_resp, exp_valid, exp_resp,
    output puf_chal, puf_en, puf_clr, exp_ready, busy, done, pass,
           last_resp, last_hd, mismatch_cnt, hd_total
  );
  modport master (
    output start, abort, seed, puf_resp, exp_valid, exp_resp,
    input  puf_chal, puf_en, puf_clr, exp_ready, busy, done, pass,
           last_resp, last_hd, mismatch_cnt, hd_total
  );
endinterface

// File: rtl/puf_challenge_verifier.sv
// puf_challenge_verifier: drives RO-PUF challenges and scores captured responses against an enrolled stream
// Ports:
//   clk   system clock
//   rst_n synchronous reset, active-high (name inherited from the top level)
//   bus   slave side of puf_challenge_verifier_if: run control (start/abort/seed),
//         PUF pins (puf_chal/puf_en/puf_clr/puf_resp), enrolled stream
//         (exp_valid/exp_resp/exp_ready) and results (busy/done/pass/last_resp/
//         last_hd/mismatch_cnt/hd_total)
module puf_challenge_verifier #(
  parameter int CHAL_W     = 5,
  parameter int RESP_W     = 8,
  parameter int NUM_CHAL   = 16,
  parameter int SETTLE_CYC = 4,
  parameter int MEAS_CYC   = 256,
  parameter int SYNC_CYC   = 3,
  parameter int MAX_HD     = 2
) (
  input logic clk,
  input logic rst_n,
  puf_challenge_verifier_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, CLEAR, SETTLE, MEASURE, WAIT_SYNC, WAIT_EXP, COMPARE, NEXT, DONE
  } state_t;
  localparam int IW = CHAL_W + 1;
  localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0]   MEAS_LAST   = 16'(MEAS_CYC - 1);
  localparam logic [15:0]   SYNC_LAST   = 16'(SYNC_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_CHAL - 1);
  localparam logic [3:0]    HD_MAX      = 4'(MAX_HD);
  state_t            state;
  logic [15:0]       cnt;
  logic [IW-1:0]     idx;
  logic [RESP_W-1:0] exp_q;
  logic [3:0]        hd;
  logic [12:0]       sum;
  always_comb begin
    hd = '0;
    for (int i = 0; i < RESP_W; i++) hd = hd + 4'(bus.last_resp[i] ^ exp_q[i]);
    sum = {1'b0, bus.hd_total} + 13'(hd);
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      idx              <= '0;
      exp_q            <= '0;
      bus.puf_en       <= 1'b0;
      bus.puf_clr      <= 1'b1;
      bus.puf_chal     <= '0;
      bus.exp_ready    <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.pass         <= 1'b0;
      bus.last_resp    <= '0;
      bus.last_hd      <= '0;
      bus.mismatch_cnt <= '0;
      bus.hd_total     <= '0;
    end else if (bus.abort && bus.busy) begin
      // results so far stay visible; a pending enrolled beat is left unconsumed
      state         <= IDLE;
      bus.puf_en    <= 1'b0;
      bus.puf_clr   <= 1'b1;
      bus.exp_ready <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          state            <= CLEAR;
          idx              <= '0;
          bus.puf_chal     <= bus.seed;
          bus.puf_clr      <= 1'b1;
          bus.busy         <= 1'b1;
          bus.done         <= 1'b0;
          bus.pass         <= 1'b0;
          bus.last_resp    <= '0;
          bus.last_hd      <= '0;
          bus.mismatch_cnt <= '0;
          bus.hd_total     <= '0;
        end
        CLEAR: begin
          state       <= SETTLE_CYC == 0 ? MEASURE : SETTLE;
          cnt         <= '0;
          bus.puf_clr <= 1'b0;
          bus.puf_en  <= SETTLE_CYC == 0;
        end
        SETTLE: if (cnt == SETTLE_LAST) begin
          state      <= MEASURE;
          cnt        <= '0;
          bus.puf_en <= 1'b1;
        end else cnt <= cnt + 1'b1;
        MEASURE: if (cnt == MEAS_LAST) begin
          state      <= WAIT_SYNC;
          cnt        <= '0;
          bus.puf_en <= 1'b0;
        end else cnt <= cnt + 1'b1;
        // puf_resp lives in the PUF clock domain; it is only sampled once the
        // oscillators have been stopped for SYNC_CYC cycles and the count is static
        WAIT_SYNC: if (cnt == SYNC_LAST) begin
          state         <= WAIT_EXP;
          bus.last_resp <= bus.puf_resp;
          bus.exp_ready <= 1'b1;
        end else cnt <= cnt + 1'b1;
        WAIT_EXP: if (bus.exp_valid && bus.exp_ready) begin
          state         <= COMPARE;
          exp_q         <= bus.exp_resp;
          bus.exp_ready <= 1'b0;
        end
        COMPARE: begin
          state        <= NEXT;
          bus.last_hd  <= hd;
          bus.hd_total <= sum[12] ? '1 : sum[11:0];
          if (hd > HD_MAX) bus.mismatch_cnt <= bus.mismatch_cnt + 1'b1;
        end
        NEXT: begin
          idx         <= idx + 1'b1;
          bus.puf_clr <= 1'b1;
          if (idx == IDX_LAST) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            bus.pass <= bus.mismatch_cnt == '0;
          end else begin
            state        <= CLEAR;
            bus.puf_chal <= bus.puf_chal + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
